sublime_nco_multi: RTL and testbench
====================================

Name: sublime_nco_multi

Overview:
- Parametrised successor to the single-channel sublime NCO: a time-multiplexed phase-accumulator NCO serving CHANNELS independent oscillators.
- One channel is serviced per enabled clock, in round-robin order.
- Each channel has its own frequency and offset register, loaded through a config write port.
- Output is a truncated wave-table address tagged with its channel index and a valid strobe, feeding a shared wavetable/synth voice pipeline.

Parameters:
- CHANNELS, 4: number of oscillators; power of two, 2..64.
- ACC_W, 32: phase accumulator, freq and offset width.
- ADDR_W, 8: output address width, taken as the top ADDR_W bits of the phase; 1 <= ADDR_W <= ACC_W.
- CH_W, $clog2(CHANNELS): channel index width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  advance the scheduler by one channel this cycle.
- sync  in  CHANNELS  per-channel phase reset, level sensitive.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  CH_W  config target channel.
- cfg_sel  in  1  0 = freq register, 1 = offset register.
- cfg_data  in  ACC_W  config write data.
- wave_addr  out  ADDR_W  phase address of the serviced channel.
- wave_ch  out  CH_W  channel index of wave_addr.
- wave_valid  out  1  wave_addr/wave_ch valid this cycle.

Behaviour:
- Reset (rst_n low, asynchronous): all acc[i], freq[i], offset[i] = 0; scheduler pointer ch = 0; wave_addr = 0, wave_ch = 0, wave_valid = 0.
- Reset deassertion is synchronised externally; first service after reset is channel 0.
- Per enabled cycle, service channel c = ch:
  - wave_addr <= (acc[c] + offset[c]) mod 2^ACC_W, bits [ACC_W-1 : ACC_W-ADDR_W].
  - acc[c] <= acc[c] + freq[c], mod 2^ACC_W (wrap is silent, no flag).
  - wave_ch <= c; wave_valid <= 1; ch <= (c + 1) mod CHANNELS.
- Latency: one clock from service to registered output. Each channel outputs once every CHANNELS enabled cycles. The first output per channel reflects phase 0, i.e. top bits of offset.
- enable low: acc, ch and config state hold; wave_valid <= 0; wave_addr and wave_ch hold their last value.
- sync[i] high: acc[i] <= 0 every cycle, regardless of enable or servicing. If channel i is serviced in the same cycle, output uses phase 0 (wave_addr = offset top bits) and acc[i] <= 0, not freq. Sync has priority over the increment.
- Config write: on cfg_we, the selected register of cfg_ch <= cfg_data at the clock edge.
  - If cfg_ch is serviced in the same cycle, the service uses the old value; the new value applies from the next service.
  - Writes never alter acc.
- Simultaneous sync on all channels plus enable: all outputs = offset top bits until sync drops.
- Storage may be flops or small RAM; in either case the behaviour above is exact at the clock edge.

Optional Feature:
- Macro: SUBLIME_NCO_MULTI_DITHER_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, reset seed 16'hACE1, advances once per enabled cycle.
  - Before truncation, the low min(16, ACC_W-ADDR_W) LFSR bits are added into the low bits of (acc+offset). This sum affects wave_addr only, never acc.
  - No dither when ADDR_W == ACC_W.
- Undefined: no LFSR logic, plain truncation as above.

Test Plan (CHANNELS=4, ACC_W=32, ADDR_W=8, macro undefined unless noted):
- Basic ramp: freq[0]=32'h08000000, offset[0]=32'h10000000, enable=1 -> ch0 wave_addr sequence 0x10, 0x18, 0x20, ... on every 4th valid; wave_ch cycles 0,1,2,3.
- Wrap: freq[1]=32'h80000000, offset[1]=0 -> ch1 outputs 0x00, 0x80, 0x00, 0x80; wrap with no glitch on other channels.
- Sync and enable:
  - Hold sync[0]=1 for 8 cycles mid-ramp -> ch0 outputs 0x10 while held; ramp restarts at 0x10, 0x18 after release.
  - enable=0 for 5 cycles -> wave_valid=0, sequence resumes at the same channel and phase.
- Config collision: write freq[2]=32'h01000000 in the cycle ch2 is serviced with old freq 0 -> next ch2 output equals previous; the one after is +0x01.
- Reset mid-operation: drop rst_n asynchronously between edges -> outputs immediately 0/0/0. After release, first valid has wave_ch=0 and wave_addr=0, since all config is cleared.
- Dither (macro defined): freq=0, offset=32'h10000000 -> wave_addr stays 0x10; offset=32'h10FFF000 -> wave_addr toggles between 0x10 and 0x11 per LFSR.

Source files
------------

// File: rtl/sublime_nco_multi.sv
// Time-multiplexed phase-accumulator NCO: CHANNELS oscillators share one adder, serviced round-robin.
// Optional LFSR dither on the output address is built when SUBLIME_NCO_MULTI_DITHER_EN is defined.
module sublime_nco_multi #(
    parameter  int CHANNELS = 4,
    parameter  int ACC_W    = 32,
    parameter  int ADDR_W   = 8,
    localparam int CH_W     = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [CHANNELS-1:0] sync,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic                cfg_sel,
    input  logic [ACC_W-1:0]    cfg_data,
    output logic [ADDR_W-1:0]   wave_addr,
    output logic [CH_W-1:0]     wave_ch,
    output logic                wave_valid
);

    logic [ACC_W-1:0] acc_reg    [CHANNELS];
    logic [ACC_W-1:0] freq_reg   [CHANNELS];
    logic [ACC_W-1:0] offset_reg [CHANNELS];
    logic [ACC_W-1:0] acc_next   [CHANNELS];
    logic [CH_W-1:0]  ch_reg;

    logic [CHANNELS-1:0] freq_we;
    logic [CHANNELS-1:0] offset_we;

    // Sync wins over the increment and applies whether or not the channel is serviced.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic svc;
            assign svc           = enable && (ch_reg == CH_W'(gi));
            assign freq_we[gi]   = cfg_we && (cfg_ch == CH_W'(gi)) && !cfg_sel;
            assign offset_we[gi] = cfg_we && (cfg_ch == CH_W'(gi)) &&  cfg_sel;
            assign acc_next[gi]  = sync[gi] ? '0
                                 : svc      ? acc_reg[gi] + freq_reg[gi]
                                 :            acc_reg[gi];
        end
    endgenerate

    logic [ACC_W-1:0] dither;

`ifdef SUBLIME_NCO_MULTI_DITHER_EN
    localparam int DITHER_W = ((ACC_W - ADDR_W) < 16) ? (ACC_W - ADDR_W) : 16;
    logic [15:0] lfsr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= 16'hACE1;
        end else if (enable) begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    generate
        if (DITHER_W > 0) begin : g_dither
            assign dither = ACC_W'(lfsr_reg[DITHER_W-1:0]);
        end else begin : g_no_dither
            assign dither = '0;
        end
    endgenerate
`else
    assign dither = '0;
`endif

    // Phase presented for the serviced channel; a synced channel reads as phase 0.
    logic [ACC_W-1:0] base_phase;
    logic [ACC_W-1:0] out_phase;

    always_comb begin
        base_phase = sync[ch_reg] ? '0 : acc_reg[ch_reg];
        out_phase  = base_phase + offset_reg[ch_reg] + dither;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_reg[i]    <= '0;
                freq_reg[i]   <= '0;
                offset_reg[i] <= '0;
            end
            ch_reg     <= '0;
            wave_addr  <= '0;
            wave_ch    <= '0;
            wave_valid <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_reg[i] <= acc_next[i];
                if (freq_we[i]) begin
                    freq_reg[i] <= cfg_data;
                end
                if (offset_we[i]) begin
                    offset_reg[i] <= cfg_data;
                end
            end
            wave_valid <= enable;
            if (enable) begin
                wave_addr <= out_phase[ACC_W-1 -: ADDR_W];
                wave_ch   <= ch_reg;
                ch_reg    <= ch_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sublime_nco_multi.sv
// Directed bench for sublime_nco_multi (4 channels, 32-bit phase, 8-bit address, no dither).
module tb_sublime_nco_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [3:0]  sync;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic        cfg_sel;
    logic [31:0] cfg_data;
    logic [7:0]  wave_addr;
    logic [1:0]  wave_ch;
    logic        wave_valid;

    int total = 0;
    int bad   = 0;

    sublime_nco_multi #(.CHANNELS(4), .ACC_W(32), .ADDR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .sync       (sync),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_sel    (cfg_sel),
        .cfg_data   (cfg_data),
        .wave_addr  (wave_addr),
        .wave_ch    (wave_ch),
        .wave_valid (wave_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic [3:0] sy;
        logic [1:0] ch;
        logic       valid;
        logic [7:0] addr;
    } vec_t;

    vec_t vecs [38];

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h expected=%h", name, idx, got, exp);
        end
    endtask

    task automatic check_out(input string name, input int idx, input logic v, input logic [1:0] c, input logic [7:0] a);
        check({name, ".valid"}, idx, 32'(wave_valid), 32'(v));
        check({name, ".ch"},    idx, 32'(wave_ch),    32'(c));
        check({name, ".addr"},  idx, 32'(wave_addr),  32'(a));
        $display("%s[%0d] valid=%0d ch=%0d addr=%h", name, idx, wave_valid, wave_ch, wave_addr);
    endtask

    task automatic step(input logic en, input logic [3:0] sy, input logic we,
                        input logic [1:0] cch, input logic sel, input logic [31:0] data);
        enable   = en;
        sync     = sy;
        cfg_we   = we;
        cfg_ch   = cch;
        cfg_sel  = sel;
        cfg_data = data;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [3:0] sy);
        step(1'b1, sy, 1'b0, 2'd0, 1'b0, 32'h0);
    endtask

    initial begin
        // {en, sync, exp ch, exp valid, exp addr}
        vecs[0]  = '{1'b1, 4'h0, 2'd0, 1'b1, 8'h10};
        vecs[1]  = '{1'b1, 4'h0, 2'd1, 1'b1, 8'h00};
        vecs[2]  = '{1'b1, 4'h0, 2'd2, 1'b1, 8'h20};
        vecs[3]  = '{1'b1, 4'h0, 2'd3, 1'b1, 8'h30};
        vecs[4]  = '{1'b1, 4'h0, 2'd0, 1'b1, 8'h18};
        vecs[5]  = '{1'b1, 4'h0, 2'd1, 1'b1, 8'h80};
        vecs[6]  = '{1'b1, 4'h0, 2'd2, 1'b1, 8'h20};
        vecs[7]  = '{1'b1, 4'h0, 2'd3, 1'b1, 8'h31};
        vecs[8]  = '{1'b0, 4'h0, 2'd3, 1'b0, 8'h31};
        vecs[9]  = '{1'b0, 4'h0, 2'd3, 1'b0, 8'h31};
        vecs[10] = '{1'b0, 4'h0, 2'd3, 1'b0, 8'h31};
        vecs[11] = '{1'b0, 4'h0, 2'd3, 1'b0, 8'h31};
        vecs[12] = '{1'b0, 4'h0, 2'd3, 1'b0, 8'h31};
        vecs[13] = '{1'b1, 4'h0, 2'd0, 1'b1, 8'h20};
        vecs[14] = '{1'b1, 4'h0, 2'd1, 1'b1, 8'h00};
        vecs[15] = '{1'b1, 4'h0, 2'd2, 1'b1, 8'h20};
        vecs[16] = '{1'b1, 4'h0, 2'd3, 1'b1, 8'h32};
        vecs[17] = '{1'b1, 4'h1, 2'd0, 1'b1, 8'h10};
        vecs[18] = '{1'b1, 4'h1, 2'd1, 1'b1, 8'h80};
        vecs[19] = '{1'b1, 4'h1, 2'd2, 1'b1, 8'h20};
        vecs[20] = '{1'b1, 4'h1, 2'd3, 1'b1, 8'h33};
        vecs[21] = '{1'b1, 4'h1, 2'd0, 1'b1, 8'h10};
        vecs[22] = '{1'b1, 4'h1, 2'd1, 1'b1, 8'h00};
        vecs[23] = '{1'b1, 4'h1, 2'd2, 1'b1, 8'h20};
        vecs[24] = '{1'b1, 4'h1, 2'd3, 1'b1, 8'h34};
        vecs[25] = '{1'b1, 4'h0, 2'd0, 1'b1, 8'h10};
        vecs[26] = '{1'b1, 4'h0, 2'd1, 1'b1, 8'h80};
        vecs[27] = '{1'b1, 4'h0, 2'd2, 1'b1, 8'h20};
        vecs[28] = '{1'b1, 4'h0, 2'd3, 1'b1, 8'h35};
        vecs[29] = '{1'b1, 4'h0, 2'd0, 1'b1, 8'h18};
        vecs[30] = '{1'b1, 4'hF, 2'd1, 1'b1, 8'h00};
        vecs[31] = '{1'b1, 4'hF, 2'd2, 1'b1, 8'h20};
        vecs[32] = '{1'b1, 4'hF, 2'd3, 1'b1, 8'h30};
        vecs[33] = '{1'b1, 4'hF, 2'd0, 1'b1, 8'h10};
        vecs[34] = '{1'b1, 4'h0, 2'd1, 1'b1, 8'h00};
        vecs[35] = '{1'b1, 4'h0, 2'd2, 1'b1, 8'h20};
        vecs[36] = '{1'b1, 4'h0, 2'd3, 1'b1, 8'h30};
        vecs[37] = '{1'b1, 4'h0, 2'd0, 1'b1, 8'h10};

        rst_n    = 1'b0;
        enable   = 1'b0;
        sync     = 4'h0;
        cfg_we   = 1'b0;
        cfg_ch   = 2'd0;
        cfg_sel  = 1'b0;
        cfg_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 0, 1'b0, 2'd0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Configuration with enable low: outputs must stay idle.
        step(1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 32'h0800_0000);
        step(1'b0, 4'h0, 1'b1, 2'd0, 1'b1, 32'h1000_0000);
        step(1'b0, 4'h0, 1'b1, 2'd1, 1'b0, 32'h8000_0000);
        step(1'b0, 4'h0, 1'b1, 2'd2, 1'b1, 32'h2000_0000);
        step(1'b0, 4'h0, 1'b1, 2'd3, 1'b0, 32'h0100_0000);
        step(1'b0, 4'h0, 1'b1, 2'd3, 1'b1, 32'h3000_0000);
        check_out("cfg_idle", 0, 1'b0, 2'd0, 8'h00);

        // Ramp, wrap, enable gap, sync on ch0, sync on all channels.
        for (int i = 0; i < 38; i++) begin
            step(vecs[i].en, vecs[i].sy, 1'b0, 2'd0, 1'b0, 32'h0);
            check_out("vec", i, vecs[i].valid, vecs[i].ch, vecs[i].addr);
        end

        // Config collision: freq[2] written in the cycle ch2 is serviced.
        run(4'h0);
        check_out("coll", 0, 1'b1, 2'd1, 8'h80);
        step(1'b1, 4'h0, 1'b1, 2'd2, 1'b0, 32'h0100_0000);
        check_out("coll", 1, 1'b1, 2'd2, 8'h20);
        run(4'h0);
        check_out("coll", 2, 1'b1, 2'd3, 8'h31);
        run(4'h0);
        check_out("coll", 3, 1'b1, 2'd0, 8'h18);
        run(4'h0);
        check_out("coll", 4, 1'b1, 2'd1, 8'h00);
        run(4'h0);
        check_out("coll", 5, 1'b1, 2'd2, 8'h20);
        repeat (3) run(4'h0);
        run(4'h0);
        check_out("coll", 6, 1'b1, 2'd2, 8'h21);

        // Asynchronous reset between edges, then restart from cleared config.
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 0, 1'b0, 2'd0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        run(4'h0);
        check_out("post_rst", 0, 1'b1, 2'd0, 8'h00);
        run(4'h0);
        check_out("post_rst", 1, 1'b1, 2'd1, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
